// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, request on bus, waiting for response)
//   arb_owner_e : which requester owns the in-flight bus transaction
//   FETCH_BE    : byte enables driven for instruction fetches (full word)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_FETCH,
    ARB_OWN_DATA
  } arb_owner_e;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one external memory port between the fetch
// stage and the memory stage, with one bus transaction outstanding at a time.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   f_req_i/f_addr_i     fetch request (held until f_gnt_o) and address
//   f_flush_i            drop the pending fetch response
//   f_gnt_o              fetch accepted (combinational, IDLE only)
//   f_valid_o/f_data_o/f_err_o   fetch response pulse, data, timeout flag
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i   data request (held until d_gnt_o)
//   d_gnt_o              data accepted (combinational, IDLE only)
//   d_valid_o/d_rdata_o/d_err_o  data response pulse, load data, timeout flag
//   bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_be_o   external bus request
//   bus_gnt_i/bus_valid_i/bus_rdata_i                   external bus handshake
//   busy_o               arbiter is not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  input  logic              f_flush_i,
  output logic              f_gnt_o,
  output logic              f_valid_o,
  output logic [DATA_W-1:0] f_data_o,
  output logic              f_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_valid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              busy_o
);

  localparam int STARVE_W = $clog2(MAX_WAIT + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WAIT);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                drop_q, drop_d;
  logic                f_valid_q, f_valid_d;
  logic                f_err_q, f_err_d;
  logic [DATA_W-1:0]   f_data_q, f_data_d;
  logic                d_valid_q, d_valid_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                fetch_win;
  logic                f_gnt, d_gnt;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_data;

  // Data has priority unless fetch has been starved long enough.
  assign fetch_win = f_req_i && (!d_req_i || (starve_cnt_q == STARVE_MAX));
  // Grants are gated by reset so every output reads 0 while reset is held.
  assign f_gnt = reset && (state_q == ARB_IDLE) && fetch_win;
  assign d_gnt = reset && (state_q == ARB_IDLE) && d_req_i && !fetch_win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    tmo_cnt_d    = tmo_cnt_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
    f_valid_d    = 1'b0;
    f_err_d      = 1'b0;
    f_data_d     = '0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = '0;
    resp_err     = 1'b0;
    resp_data    = '0;

    if (f_gnt) begin
      starve_cnt_d = '0;
    end else if (f_req_i && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (f_gnt) begin
          state_d     = ARB_REQ;
          owner_d     = ARB_OWN_FETCH;
          bus_we_d    = 1'b0;
          bus_addr_d  = f_addr_i;
          bus_wdata_d = '0;
          bus_be_d    = FETCH_BE;
        end else if (d_gnt) begin
          state_d     = ARB_REQ;
          owner_d     = ARB_OWN_DATA;
          bus_we_d    = d_we_i;
          bus_addr_d  = d_addr_i;
          bus_wdata_d = d_wdata_i;
          bus_be_d    = d_be_i;
        end
      end
      ARB_REQ: begin
        if (f_flush_i && (owner_q == ARB_OWN_FETCH)) drop_d = 1'b1;
        if (bus_gnt_i) begin
          state_d   = ARB_WAIT;
          tmo_cnt_d = '0;
        end
      end
      ARB_WAIT: begin
        if (f_flush_i && (owner_q == ARB_OWN_FETCH)) drop_d = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A response arriving on the timeout cycle takes precedence.
        if (bus_valid_i || (tmo_cnt_q == TMO_LAST)) begin
          state_d   = ARB_IDLE;
          resp_err  = !bus_valid_i;
          resp_data = (bus_valid_i && !bus_we_q) ? bus_rdata_i : '0;
          if (owner_q == ARB_OWN_FETCH) begin
            // A flush on the final WAIT cycle still suppresses the response.
            if (!(drop_q || f_flush_i)) begin
              f_valid_d = 1'b1;
              f_err_d   = resp_err;
              f_data_d  = resp_data;
            end
          end else begin
            d_valid_d = 1'b1;
            d_err_d   = resp_err;
            d_rdata_d = resp_data;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_OWN_FETCH;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      drop_q       <= 1'b0;
      f_valid_q    <= 1'b0;
      f_err_q      <= 1'b0;
      f_data_q     <= '0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      drop_q       <= drop_d;
      f_valid_q    <= f_valid_d;
      f_err_q      <= f_err_d;
      f_data_q     <= f_data_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign f_gnt_o     = f_gnt;
  assign d_gnt_o     = d_gnt;
  assign f_valid_o   = f_valid_q;
  assign f_err_o     = f_err_q;
  assign f_data_o    = f_data_q;
  assign d_valid_o   = d_valid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
  assign bus_req_o   = (state_q == ARB_REQ);
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;
  assign busy_o      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. The reference model works at the
// transaction level: when a grant is predicted, the bench picks the bus
// grant and response delays itself, so the whole timeline of that
// transaction (bus_req window, completion cycle, error, data) is computed
// arithmetically at grant time.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int TIMEOUT  = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req_i, f_flush_i, f_gnt_o, f_valid_o, f_err_o;
  logic [ADDR_W-1:0] f_addr_i;
  logic [DATA_W-1:0] f_data_o;
  logic              d_req_i, d_we_i, d_gnt_o, d_valid_o, d_err_o;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i, d_rdata_o;
  logic [3:0]        d_be_i;
  logic              bus_req_o, bus_we_o, bus_gnt_i, bus_valid_i, busy_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o, bus_rdata_i;
  logic [3:0]        bus_be_o;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_flush_i(f_flush_i),
    .f_gnt_o(f_gnt_o), .f_valid_o(f_valid_o), .f_data_o(f_data_o), .f_err_o(f_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_valid_i(bus_valid_i), .bus_rdata_i(bus_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Stimulus knobs (percentages / maximum delays).
  int p_f, p_d, p_flush, p_stray, p_to, p_edge, gd_max, rd_max;
  logic              fixed_rd_en;
  logic [DATA_W-1:0] fixed_rd;

  // Requester model: a request is held until it is granted.
  logic              f_pend, d_pend, d_we;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, tx_rdata, tx_wdata;
  logic [3:0]        d_be, tx_be;
  int                starve;

  // In-flight transaction model.
  logic              tx_act, tx_fetch, tx_we, tx_drop, tx_err;
  logic [ADDR_W-1:0] tx_addr;
  int                tx_g, tx_bgnt, tx_went, tx_bval, tx_end;

  task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_knobs(int pf, int pd, int pfl, int pst, int pto, int ped, int gdm, int rdm);
    p_f = pf; p_d = pd; p_flush = pfl; p_stray = pst;
    p_to = pto; p_edge = ped; gd_max = gdm; rd_max = rdm;
  endtask

  // One clock cycle: drive inputs, predict and compare, advance the model.
  task automatic step();
    logic fw, dw, in_wait, stray, exp_fv, exp_dv, exp_busy, exp_breq;
    logic [DATA_W-1:0] exp_data;
    int gd, sel;
    if (!f_pend && ($urandom_range(99) < p_f)) begin
      f_pend = 1'b1; f_addr = $urandom;
    end
    if (!d_pend && ($urandom_range(99) < p_d)) begin
      d_pend = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
      d_wdata = $urandom; d_be = 4'($urandom_range(15));
    end
    in_wait = tx_act && (cyc >= tx_went) && (cyc < tx_end);
    stray   = !in_wait && ($urandom_range(99) < p_stray);
    f_req_i = f_pend; f_addr_i = f_addr;
    d_req_i = d_pend; d_we_i = d_we; d_addr_i = d_addr; d_wdata_i = d_wdata; d_be_i = d_be;
    f_flush_i   = ($urandom_range(99) < p_flush);
    bus_gnt_i   = tx_act && (cyc == tx_bgnt);
    bus_valid_i = (tx_act && (cyc == tx_bval)) || stray;
    bus_rdata_i = (tx_act && (cyc == tx_bval)) ? tx_rdata : $urandom;
    #1;

    exp_busy = tx_act && (cyc > tx_g) && (cyc < tx_end);
    exp_breq = tx_act && (cyc > tx_g) && (cyc <= tx_bgnt);
    exp_fv   = tx_act && (cyc == tx_end) && tx_fetch && !tx_drop;
    exp_dv   = tx_act && (cyc == tx_end) && !tx_fetch;
    exp_data = (tx_err || tx_we) ? '0 : tx_rdata;
    fw = 1'b0; dw = 1'b0;
    if (!tx_act || (cyc >= tx_end)) begin
      fw = f_pend && (!d_pend || (starve == MAX_WAIT));
      dw = d_pend && !fw;
    end

    check_val("f_gnt", 64'(f_gnt_o), 64'(fw));
    check_val("d_gnt", 64'(d_gnt_o), 64'(dw));
    check_val("f_valid", 64'(f_valid_o), 64'(exp_fv));
    check_val("d_valid", 64'(d_valid_o), 64'(exp_dv));
    check_val("busy", 64'(busy_o), 64'(exp_busy));
    check_val("bus_req", 64'(bus_req_o), 64'(exp_breq));
    if (exp_breq) begin
      check_val("bus_addr", 64'(bus_addr_o), 64'(tx_addr));
      check_val("bus_we", 64'(bus_we_o), 64'(tx_we));
      check_val("bus_be", 64'(bus_be_o), 64'(tx_be));
      if (!tx_fetch) check_val("bus_wdata", 64'(bus_wdata_o), 64'(tx_wdata));
    end
    if (exp_fv) begin
      check_val("f_err", 64'(f_err_o), 64'(tx_err));
      check_val("f_data", 64'(f_data_o), 64'(exp_data));
    end
    if (exp_dv) begin
      check_val("d_err", 64'(d_err_o), 64'(tx_err));
      check_val("d_rdata", 64'(d_rdata_o), 64'(exp_data));
    end
    if (tx_act && (cyc == tx_end))
      $display("[TB] cyc=%0d txn %s addr=%0h we=%0d err=%0d drop=%0d data=%0h",
               cyc, tx_fetch ? "fetch" : "data", tx_addr, tx_we, tx_err, tx_drop, exp_data);

    if (tx_act && tx_fetch && (cyc > tx_g) && (cyc < tx_end) && f_flush_i) tx_drop = 1'b1;

    if (fw) starve = 0;
    else if (f_pend && (starve < MAX_WAIT)) starve++;

    if (fw || dw) begin
      tx_act   = 1'b1;
      tx_fetch = fw;
      tx_drop  = 1'b0;
      tx_addr  = fw ? f_addr : d_addr;
      tx_we    = fw ? 1'b0 : d_we;
      tx_be    = fw ? 4'hF : d_be;
      tx_wdata = d_wdata;
      tx_rdata = fixed_rd_en ? fixed_rd : $urandom;
      gd       = $urandom_range(gd_max);
      tx_g     = cyc;
      tx_bgnt  = cyc + 1 + gd;
      tx_went  = cyc + 2 + gd;
      sel      = $urandom_range(99);
      if (sel < p_to)               tx_bval = -1;
      else if (sel < p_to + p_edge) tx_bval = tx_went + TIMEOUT - 1;
      else                          tx_bval = tx_went + $urandom_range(rd_max);
      tx_err   = (tx_bval < 0);
      tx_end   = tx_err ? (tx_went + TIMEOUT) : (tx_bval + 1);
      if (fw) f_pend = 1'b0;
      else    d_pend = 1'b0;
    end

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(string tag);
    check_val({tag, "_gnt"}, 64'({f_gnt_o, d_gnt_o}), 64'(0));
    check_val({tag, "_valid"}, 64'({f_valid_o, d_valid_o, f_err_o, d_err_o}), 64'(0));
    check_val({tag, "_f_data"}, 64'(f_data_o), 64'(0));
    check_val({tag, "_d_rdata"}, 64'(d_rdata_o), 64'(0));
    check_val({tag, "_bus_ctl"}, 64'({bus_req_o, bus_we_o, bus_be_o, busy_o}), 64'(0));
    check_val({tag, "_bus_addr"}, 64'(bus_addr_o), 64'(0));
    check_val({tag, "_bus_wdata"}, 64'(bus_wdata_o), 64'(0));
  endtask

  // Asynchronous reset in the middle of a clock cycle; the model forgets
  // the transaction, the starvation count and both pending requests.
  task automatic async_reset();
    #3 reset = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    f_req_i = 1'b0; d_req_i = 1'b0; bus_gnt_i = 1'b0; bus_valid_i = 1'b0;
    tx_act = 1'b0; starve = 0; f_pend = 1'b0; d_pend = 1'b0;
    @(posedge clk); #1;
    cyc += 4;
  endtask

  initial begin
    reset = 1'b0;
    f_req_i = 0; f_addr_i = '0; f_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    bus_gnt_i = 0; bus_valid_i = 0; bus_rdata_i = '0;
    f_pend = 0; d_pend = 0; d_we = 0; f_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    tx_act = 0; tx_fetch = 0; tx_we = 0; tx_drop = 0; tx_err = 0; tx_addr = '0;
    tx_rdata = '0; tx_wdata = '0; tx_be = '0;
    tx_g = 0; tx_bgnt = 0; tx_went = 0; tx_bval = -1; tx_end = 0; starve = 0;
    fixed_rd_en = 0; fixed_rd = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_init");
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch at 0x100, immediate bus grant, response one cycle later.
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
    fixed_rd_en = 1; fixed_rd = 32'h0000_0013;
    f_pend = 1; f_addr = 32'h100;
    run(6);
    fixed_rd_en = 0;

    // Simultaneous fetch and data write: data first, fetch on d_valid cycle.
    f_pend = 1; f_addr = 32'h104;
    d_pend = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    run(10);

    // Starvation: both requesters always busy, fastest bus.
    set_knobs(100, 100, 0, 0, 0, 0, 0, 0);
    run(120);

    // Timeout on a data request, then stray responses while idle.
    set_knobs(0, 0, 0, 0, 100, 0, 2, 0);
    d_pend = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
    run(TIMEOUT + 10);
    set_knobs(0, 0, 0, 60, 0, 0, 0, 0);
    run(10);

    // Flush during a slow fetch, then a normal fetch.
    set_knobs(0, 0, 30, 0, 0, 0, 0, 0);
    rd_max = 0; gd_max = 0;
    fixed_rd_en = 1; fixed_rd = 32'h1234;
    f_pend = 1; f_addr = 32'h200;
    p_edge = 0; rd_max = 6;
    run(10);
    fixed_rd_en = 0;
    set_knobs(0, 0, 0, 0, 0, 0, 1, 3);
    f_pend = 1; f_addr = 32'h204;
    run(10);

    // Timeout boundary: response lands on the last WAIT cycle.
    set_knobs(0, 0, 0, 0, 0, 100, 0, 0);
    d_pend = 1; d_we = 0; d_addr = 32'h4000; d_be = 4'hF;
    run(TIMEOUT + 6);

    // Mixed random traffic.
    set_knobs(40, 40, 5, 10, 2, 1, 3, 6);
    run(2500);

    // Reset while a data transaction sits in WAIT; stale response afterwards.
    set_knobs(0, 0, 0, 0, 100, 0, 0, 0);
    run(TIMEOUT + 5);
    d_pend = 1; d_we = 0; d_addr = 32'h5000; d_be = 4'hF;
    run(5);
    check_val("pre_rst_busy", 64'(busy_o), 64'(1));
    async_reset();
    set_knobs(0, 0, 0, 100, 0, 0, 0, 0);
    run(5);

    set_knobs(50, 50, 5, 10, 1, 1, 2, 4);
    run(600);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- One transaction is outstanding at a time.
- Data requests have fixed priority; a starvation counter guarantees fetch progress.
- A bus timeout returns an error response, and a fetch flush on a taken branch drops the pending fetch response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 15, fetch-pending cycles before fetch wins over data.
- TIMEOUT, 255, WAIT-state cycles before the arbiter aborts with an error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- f_req_i  in  1  fetch request; held until f_gnt_o.
- f_addr_i  in  ADDR_W  fetch address.
- f_flush_i  in  1  discard any pending fetch response.
- f_gnt_o  out  1  fetch request accepted.
- f_valid_o  out  1  fetch response valid, one-cycle pulse.
- f_data_o  out  DATA_W  fetched instruction.
- f_err_o  out  1  fetch timed out; qualifies f_valid_o.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_we_i  in  1  write enable.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_be_i  in  4  byte enables.
- d_gnt_o  out  1  data request accepted.
- d_valid_o  out  1  data response valid, one-cycle pulse.
- d_rdata_o  out  DATA_W  load data; 0 for writes.
- d_err_o  out  1  data timed out; qualifies d_valid_o.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_be_o  out  4  bus byte enables; fetch uses 4'hF.
- bus_gnt_i  in  1  bus accepted the request.
- bus_valid_i  in  1  bus response valid.
- bus_rdata_i  in  DATA_W  bus read data.
- busy_o  out  1  arbiter state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any state, including mid-transaction):
  - state=IDLE; owner, counters and all registered outputs cleared to 0.
  - The in-flight bus transaction is abandoned and its later response is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - With no request, stay in IDLE.
  - Winner selection: data wins, unless starve_cnt==MAX_WAIT and f_req_i=1, then fetch wins.
  - Combinationally pulse the winner's gnt_o in the same cycle.
  - Register the owner, we, addr, wdata and be (fetch: we=0, be=4'hF) into bus_* outputs; go to REQ.
- REQ:
  - bus_req_o=1 and bus_* stable until bus_gnt_i=1; then go to WAIT and clear tmo_cnt.
  - No timeout applies in REQ.
- WAIT:
  - tmo_cnt increments each cycle.
  - On bus_valid_i=1: capture bus_rdata_i (0 if write); next cycle pulse owner valid_o with err_o=0; go to IDLE.
  - Else if tmo_cnt==TIMEOUT-1: next cycle pulse owner valid_o with err_o=1 and data=0; go to IDLE.
  - bus_valid_i arriving in the same cycle as the timeout: the response wins and no error is reported.
- Latency:
  - Minimum request to valid_o is 3 cycles: gnt at cycle 0, bus_req at 1, bus_gnt at 1, bus_valid at 2, valid_o at 3.
  - IDLE is re-entered on the valid_o cycle, so a new grant can occur in that cycle: back-to-back transactions have a 3-cycle period.
- Starvation counter:
  - starve_cnt increments, saturating at MAX_WAIT, in every cycle where f_req_i=1 and fetch is not granted.
  - Cleared when fetch is granted.
- Flush:
  - f_flush_i=1 while owner=fetch in REQ or WAIT sets a drop flag; the bus transaction still completes, but f_valid_o is suppressed.
  - The drop flag clears on return to IDLE.
  - f_flush_i in IDLE has no effect.
- bus_valid_i in IDLE or REQ is a stray and is ignored.
- Only one of f_valid_o / d_valid_o is ever high in a cycle.
- A gnt_o is never asserted outside IDLE.

Decomposition:
- core_package gains:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT};
  - arb_owner_e {ARB_OWN_FETCH, ARB_OWN_DATA}.
- No sub-module; the counters are inline.

Test Plan:
- Single fetch: f_req_i at addr 0x100, bus grants immediately and returns 0x00000013 after 1 cycle -> f_gnt_o at cycle 0, bus_addr_o=0x100 with be=F, f_valid_o at cycle 3 with f_data_o=0x13 and f_err_o=0.
- Simultaneous requests: f_req_i and d_req_i (write 0xDEADBEEF, be=0011) together -> data granted first with bus_we_o=1, bus_be_o=0011; fetch granted in the cycle d_valid_o pulses; d_rdata_o=0.
- Starvation: hold d_req_i and f_req_i continuously -> fetch granted once starve_cnt reaches 15, then starve_cnt resets to 0.
- Timeout: bus_valid_i never asserted after the data grant -> d_valid_o with d_err_o=1 and d_rdata_o=0 exactly TIMEOUT cycles after WAIT entry; busy_o drops; a later stray bus_valid_i produces no response.
- Flush: fetch in WAIT, f_flush_i pulse, bus later returns 0x1234 -> no f_valid_o; the next fetch completes normally.
- Reset in WAIT: reset=0 asynchronously -> all outputs 0 immediately and state IDLE; after release, a stale bus_valid_i is ignored.
